// File: rtl/ndn_prefix_parser.sv
// Byte-serial NDN front end: classifies Interest/Data, extracts the name
// prefix and holds it with a strobe until the PIT reports completion.
module ndn_prefix_parser #(
   parameter int          MAX_NAME_BYTES = 8,
   parameter logic [7:0]  TYPE_INTEREST  = 8'h05,
   parameter logic [7:0]  TYPE_DATA      = 8'h06
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_byte,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic [63:0] prefix,
   output logic [5:0]  len,
   output logic        interest_out,
   output logic        data_out,
   input  logic        pit_done,
   output logic [7:0]  err_count
);

   localparam logic [7:0] MAXB = 8'(MAX_NAME_BYTES);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_NAME, S_SKIP, S_HOLD
   } state_t;

   state_t      r_state, w_next;
   logic        r_kind, r_err;
   logic [5:0]  r_len;
   logic [2:0]  r_idx;
   logic [63:0] r_prefix;
   logic [7:0]  r_err_count;

   logic w_beat, w_bad, w_lat_kind, w_err_set;
   logic w_start, w_wr, w_name_done, w_known;

   assign w_beat      = in_valid && in_ready;
   assign w_name_done = (({3'b000, r_idx} + 6'd1) == r_len);
   assign w_known     = (in_byte == TYPE_INTEREST) ||
                        (in_byte == TYPE_DATA);

   always_comb begin
      w_next     = r_state;
      w_bad      = 1'b0;
      w_lat_kind = 1'b0;
      w_err_set  = 1'b0;
      w_start    = 1'b0;
      w_wr       = 1'b0;
      unique case (r_state)
         S_IDLE: if (w_beat) begin
            if (in_last) begin
               w_bad  = 1'b1;
               w_next = S_IDLE;
            end else if (w_known) begin
               w_lat_kind = 1'b1;
               w_next     = S_LEN;
            end else begin
               w_err_set = 1'b1;
               w_next    = S_SKIP;
            end
         end
         S_LEN: if (w_beat) begin
            if (in_last) begin
               w_bad  = 1'b1;
               w_next = S_IDLE;
            end else if (in_byte == 8'd0 || in_byte > MAXB) begin
               w_err_set = 1'b1;
               w_next    = S_SKIP;
            end else begin
               w_start = 1'b1;
               w_next  = S_NAME;
            end
         end
         S_NAME: if (w_beat) begin
            w_wr = 1'b1;
            if (w_name_done) begin
               w_next = in_last ? S_HOLD : S_SKIP;
            end else if (in_last) begin
               w_bad  = 1'b1;
               w_next = S_IDLE;
            end
         end
         S_SKIP: if (w_beat && in_last) begin
            // Error flag decides between drop-and-count and delivery
            if (r_err) begin
               w_bad  = 1'b1;
               w_next = S_IDLE;
            end else begin
               w_next = S_HOLD;
            end
         end
         S_HOLD: if (pit_done) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_kind      <= 1'b0;
         r_err       <= 1'b0;
         r_len       <= 6'd0;
         r_idx       <= 3'd0;
         r_prefix    <= 64'd0;
         r_err_count <= 8'd0;
      end else begin
         r_state <= w_next;
         if (w_lat_kind) begin
            r_kind <= (in_byte == TYPE_DATA);
            r_err  <= 1'b0;
         end
         if (w_err_set) r_err <= 1'b1;
         if (w_start) begin
            r_len    <= in_byte[5:0];
            r_idx    <= 3'd0;
            r_prefix <= 64'd0;
         end
         if (w_wr) begin
            r_prefix <= r_prefix | ({in_byte, 56'd0} >> {r_idx, 3'b000});
            r_idx    <= r_idx + 3'd1;
         end
         if (w_bad && r_err_count != 8'hFF)
            r_err_count <= r_err_count + 8'd1;
      end
   end

   assign in_ready     = !rst && (r_state != S_HOLD);
   assign interest_out = (r_state == S_HOLD) && !r_kind;
   assign data_out     = (r_state == S_HOLD) && r_kind;
   assign prefix       = r_prefix;
   assign len          = r_len;
   assign err_count    = r_err_count;

endmodule

// File: doc/ndn_prefix_parser.md
# ndn_prefix_parser

Byte-serial NDN packet front end that sits directly upstream of the PIT hash table. It accepts one packet at a time as a byte stream and classifies it as Interest or Data. It extracts the name prefix (up to 8 bytes, left-aligned into 64 bits) and its byte length, then holds them with an Interest or Data strobe until the PIT signals completion. Malformed packets are dropped and counted.

## Interface
Parameters:
- MAX_NAME_BYTES, 8, maximum accepted name length in bytes; must be 8 or less.
- TYPE_INTEREST, 8'h05, type byte that marks an Interest.
- TYPE_DATA, 8'h06, type byte that marks a Data packet.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_byte  in  8  packet byte.
- in_valid  in  1  in_byte is valid this cycle.
- in_last  in  1  in_byte is the final byte of the packet.
- in_ready  out  1  parser accepts a byte; a beat transfers when in_valid && in_ready.
- prefix  out  64  name bytes; first name byte in [63:56]; unused low bytes are 0.
- len  out  6  name length in bytes, 1..MAX_NAME_BYTES.
- interest_out  out  1  held prefix/len came from an Interest (drives the PIT out_bit).
- data_out  out  1  held prefix/len came from a Data packet (drives the PIT prefix_ready).
- pit_done  in  1  PIT finished with the request (its pit_in_bit OR rejected).
- err_count  out  8  count of malformed packets; saturates at 255.

## Operation
- Packet format: byte0 = type; byte1 = L (name length); bytes 2..L+1 = name; any remaining bytes are payload, which is skipped.
- States:
  - IDLE: wait for the type beat. On a known type, latch the kind and go to LEN. On an unknown type, go to SKIP with the error flag set.
  - LEN: latch L. If L==0 or L>MAX_NAME_BYTES, go to SKIP with the error flag set. Otherwise clear prefix and go to NAME.
  - NAME: shift each byte into prefix at position [63-8k -: 8], where k = byte index from 0. After L bytes, go to HOLD if that beat has in_last; otherwise go to SKIP.
  - SKIP: discard beats until an in_last beat. Then go to HOLD if the error flag is clear; otherwise go to IDLE and increment err_count.
  - HOLD: in_ready=0. Assert interest_out or data_out, never both. prefix and len stay stable. When pit_done=1, go to IDLE and deassert the strobe on the next edge.
- Early in_last rule: an in_last beat in IDLE (the type byte), in LEN, or in NAME before byte L counts as malformed. increment err_count and go to IDLE; no strobe is issued.
- in_ready is 1 in IDLE, LEN, NAME and SKIP; it is 0 only in HOLD.
- pit_done outside HOLD is ignored.
- err_count increments by 1 per malformed packet and holds at 8'hFF.
- prefix and len keep their last values in IDLE; they are overwritten only on entry to NAME and during NAME.

## Timing
- Reset values: in_ready=0 while rst is high and 1 from the first cycle after release. prefix=0, len=0, interest_out=0, data_out=0, err_count=0, state=IDLE.
- The strobe asserts on the clock edge that accepts the packet's final beat, so it is visible the next cycle.
- Minimum packet (type, L=1, one name byte with in_last): strobe is high 3 cycles after the first beat, assuming back-to-back beats.
- pit_done sampled high in HOLD: strobe is low and in_ready is 1 on the following cycle, so a new packet can start 1 cycle after pit_done.
- Idle cycles (in_valid=0) in any state leave the state unchanged.
- rst mid-packet or in HOLD: return immediately to reset values. The partial packet is discarded and not counted; the upstream sender restarts from byte0.

## Test plan
- Interest 05,03,41,42,43 with in_last on 43 -> interest_out=1, prefix=64'h4142_4300_0000_0000, len=3, in_ready=0; hold 4 cycles, pulse pit_done -> strobe 0 and in_ready 1 the next cycle.
- Data 06,08,01..08 followed by 4 payload bytes with in_last -> data_out=1 only after the last payload byte, prefix=64'h0102030405060708, len=8.
- Bad length 05,09,... and 05,00,... -> no strobe, err_count 0→1→2, parser returns to IDLE.
- Unknown type 07,02,AA,BB(last), then truncated 05,04,11(last) -> err_count +2, no strobe; the next valid Interest is still parsed correctly.
- Saturation: 260 malformed packets -> err_count=255.
- Assert rst while in NAME, and again while in HOLD -> all outputs return to their reset values and err_count=0; a subsequent valid packet parses normally.
